// File: rtl/fetch_decode_stage.sv
// RV32I front end: PC register, single-outstanding instruction fetch,
// fetch/decode slot with skid buffer, opcode pre-decode into immsrc/class flags.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [1:0]  immsrc,
    output logic        is_load,
    output logic        is_store,
    output logic        is_branch,
    output logic        is_alu,
    output logic        illegal
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_RST,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_DISCARD
    } state_t;

    typedef struct packed {
        logic [1:0] immsrc;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_alu;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] opcode);
        dec_t d;
        d = '0;
        case (opcode)
            7'b0000011: d.is_load   = 1'b1;
            7'b0010011: d.is_alu    = 1'b1;
            7'b1100111: d.immsrc    = 2'b00;
            7'b0100011: begin
                d.immsrc   = 2'b01;
                d.is_store = 1'b1;
            end
            7'b1100011: begin
                d.immsrc    = 2'b10;
                d.is_branch = 1'b1;
            end
            7'b0110011: d.is_alu    = 1'b1;
            default:    d.illegal   = 1'b1;
        endcase
        return d;
    endfunction

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        skid_valid;
    dec_t        id_dec;

    logic        slot_free;
    logic        load_en;
    logic [31:0] load_instr;
    logic [31:0] load_pc;

    assign imem_addr = pc;
    assign immsrc    = id_dec.immsrc;
    assign is_load   = id_dec.is_load;
    assign is_store  = id_dec.is_store;
    assign is_branch = id_dec.is_branch;
    assign is_alu    = id_dec.is_alu;
    assign illegal   = id_dec.illegal;

    assign slot_free = !id_valid || !stall;

    // Slot source: a fresh response in WAIT, or the skid buffer once HOLD drains.
    always_comb begin
        load_en    = 1'b0;
        load_instr = imem_rdata;
        load_pc    = pc;
        if (!redirect) begin
            if (state == ST_WAIT && imem_rvalid && slot_free) begin
                load_en = 1'b1;
            end else if (state == ST_HOLD && !stall && skid_valid) begin
                load_en    = 1'b1;
                load_instr = skid_instr;
                load_pc    = skid_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RST;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_instr   <= NOP;
            id_dec     <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
            skid_valid <= 1'b0;
        end else begin
            imem_req <= 1'b0;
            if (!stall) begin
                id_valid <= 1'b0;
            end

            if (load_en) begin
                id_valid <= 1'b1;
                id_pc    <= load_pc;
                id_instr <= load_instr;
                id_dec   <= decode(load_instr[6:0]);
                pc       <= load_pc + 32'd4;
            end

            if (redirect) begin
                // Redirect outranks stall and rvalid; any in-flight response is dropped.
                pc         <= redirect_pc & ~32'd3;
                id_valid   <= 1'b0;
                skid_valid <= 1'b0;
                case (state)
                    ST_ISSUE:   state <= ST_DISCARD;
                    ST_WAIT: begin
                        if (imem_rvalid) begin
                            state    <= ST_ISSUE;
                            imem_req <= 1'b1;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end
                    ST_DISCARD: state <= ST_DISCARD;
                    default: begin
                        state    <= ST_ISSUE;
                        imem_req <= 1'b1;
                    end
                endcase
            end else begin
                case (state)
                    ST_RST: begin
                        state    <= ST_ISSUE;
                        imem_req <= 1'b1;
                    end
                    ST_ISSUE: state <= ST_WAIT;
                    ST_WAIT: begin
                        if (imem_rvalid) begin
                            if (slot_free) begin
                                state    <= ST_ISSUE;
                                imem_req <= 1'b1;
                            end else begin
                                skid_instr <= imem_rdata;
                                skid_pc    <= pc;
                                skid_valid <= 1'b1;
                                state      <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!stall) begin
                            skid_valid <= 1'b0;
                            state      <= ST_ISSUE;
                            imem_req   <= 1'b1;
                        end
                    end
                    ST_DISCARD: begin
                        if (imem_rvalid) begin
                            state    <= ST_ISSUE;
                            imem_req <= 1'b1;
                        end
                    end
                    default: state <= ST_RST;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: decode vector table plus stall,
// redirect and PC-wrap sequences against a latency-programmable memory model.
module tb_fetch_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [1:0]  immsrc;
    logic        is_load, is_store, is_branch, is_alu, illegal;

    int checks = 0;
    int errors = 0;

    fetch_decode_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .immsrc(immsrc), .is_load(is_load), .is_store(is_store),
        .is_branch(is_branch), .is_alu(is_alu), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Memory model: response arrives mem_k cycles after the request cycle.
    logic [31:0] rom [16];
    int          mem_k = 1;
    int          rem = 0;
    logic [31:0] req_addr = '0;

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (rem > 0) begin
            rem = rem - 1;
            if (rem == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = rom[req_addr[5:2]];
            end
        end
        if (imem_req) begin
            rem      = mem_k;
            req_addr = imem_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] flags();
        return {27'd0, is_load, is_store, is_branch, is_alu, illegal};
    endfunction

    // flags packed as {load, store, branch, alu, illegal}
    typedef struct {
        logic [31:0] instr;
        logic [1:0]  exp_immsrc;
        logic [4:0]  exp_flags;
    } vec_t;

    vec_t vecs [8];

    localparam logic [31:0] W_ADDI = 32'h0050_0093;
    localparam logic [31:0] W_SW   = 32'h0011_2223;

    initial begin
        vecs[0] = '{32'h0050_0093, 2'b00, 5'b00010};
        vecs[1] = '{32'h0011_2223, 2'b01, 5'b01000};
        vecs[2] = '{32'h0020_8463, 2'b10, 5'b00100};
        vecs[3] = '{32'h0000_2083, 2'b00, 5'b10000};
        vecs[4] = '{32'h0020_81b3, 2'b00, 5'b00010};
        vecs[5] = '{32'h0000_80e7, 2'b00, 5'b00000};
        vecs[6] = '{32'h0000_006f, 2'b00, 5'b00001};
        vecs[7] = '{32'h0000_0037, 2'b00, 5'b00001};
        for (int i = 0; i < 16; i++) rom[i] = 32'h0000_0013;
        for (int i = 0; i < 8; i++) rom[i] = vecs[i].instr;

        // Reset state
        mem_k = 1;
        do_reset();
        rst_n = 1'b0;
        tick();
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_instr", id_instr, 32'h0000_0013);
        check("rst_immsrc", {30'd0, immsrc}, 32'd0);
        check("rst_flags", flags(), 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        rst_n = 1'b1;

        // First fetch timing after release
        tick();
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'd0);
        tick();
        check("wait_req", {31'd0, imem_req}, 32'd0);
        check("wait_valid", {31'd0, id_valid}, 32'd0);
        tick();
        check("first_valid", {31'd0, id_valid}, 32'd1);
        check("first_next_addr", imem_addr, 32'd4);
        check("first_next_req", {31'd0, imem_req}, 32'd1);

        // Decode table over sequential fetches, stall=0
        for (int i = 0; i < 8; i++) begin
            int n;
            n = 0;
            while (!id_valid && n < 10) begin
                tick();
                n++;
            end
            check($sformatf("v%0d_valid", i), {31'd0, id_valid}, 32'd1);
            check($sformatf("v%0d_pc", i), id_pc, 32'(i * 4));
            check($sformatf("v%0d_instr", i), id_instr, vecs[i].instr);
            check($sformatf("v%0d_immsrc", i), {30'd0, immsrc}, {30'd0, vecs[i].exp_immsrc});
            check($sformatf("v%0d_flags", i), flags(), {27'd0, vecs[i].exp_flags});
            tick();
        end

        // Stall for 4 cycles while the next response lands in the skid buffer
        rom[0] = W_ADDI;
        rom[1] = W_SW;
        do_reset();
        tick(); tick(); tick();
        check("st_first", id_instr, W_ADDI);
        stall = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_hold_valid", {31'd0, id_valid}, 32'd1);
            check("st_hold_pc", id_pc, 32'd0);
            check("st_hold_instr", id_instr, W_ADDI);
            check("st_hold_alu", {31'd0, is_alu}, 32'd1);
            check("st_hold_req", {31'd0, imem_req}, 32'd0);
            check("st_hold_addr", imem_addr, 32'd4);
        end
        stall = 1'b0;
        tick();
        check("st_drain_valid", {31'd0, id_valid}, 32'd1);
        check("st_drain_pc", id_pc, 32'd4);
        check("st_drain_instr", id_instr, W_SW);
        check("st_drain_immsrc", {30'd0, immsrc}, 32'd1);
        check("st_drain_store", {31'd0, is_store}, 32'd1);
        check("st_drain_req", {31'd0, imem_req}, 32'd1);
        check("st_drain_addr", imem_addr, 32'd8);

        // Redirect during ISSUE with 3-cycle memory latency
        mem_k = 3;
        do_reset();
        tick();
        check("ri_req", {31'd0, imem_req}, 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("ri_disc_valid", {31'd0, id_valid}, 32'd0);
            check("ri_disc_req", {31'd0, imem_req}, 32'd0);
            check("ri_disc_addr", imem_addr, 32'h0000_0100);
            tick();
        end
        check("ri_disc_valid2", {31'd0, id_valid}, 32'd0);
        tick();
        check("ri_reissue_req", {31'd0, imem_req}, 32'd1);
        check("ri_reissue_addr", imem_addr, 32'h0000_0100);
        check("ri_reissue_valid", {31'd0, id_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ri_wait_valid", {31'd0, id_valid}, 32'd0);
        end
        tick();
        check("ri_land_valid", {31'd0, id_valid}, 32'd1);
        check("ri_land_pc", id_pc, 32'h0000_0100);

        // Redirect coincident with rvalid in WAIT while stalled
        mem_k = 1;
        do_reset();
        tick(); tick(); tick();
        stall = 1'b1;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        check("rw_valid", {31'd0, id_valid}, 32'd0);
        check("rw_req", {31'd0, imem_req}, 32'd1);
        check("rw_addr", imem_addr, 32'h0000_0040);
        tick(); tick();
        check("rw_land_valid", {31'd0, id_valid}, 32'd1);
        check("rw_land_pc", id_pc, 32'h0000_0040);
        stall = 1'b0;

        // Illegal opcode fetched at the top of the address space, PC wraps
        rom[15] = 32'hFFFF_FFFF;
        do_reset();
        tick();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        check("wr_req", {31'd0, imem_req}, 32'd1);
        check("wr_addr", imem_addr, 32'hFFFF_FFFC);
        tick(); tick();
        check("wr_valid", {31'd0, id_valid}, 32'd1);
        check("wr_pc", id_pc, 32'hFFFF_FFFC);
        check("wr_illegal", {31'd0, illegal}, 32'd1);
        check("wr_immsrc", {30'd0, immsrc}, 32'd0);
        check("wr_next_addr", imem_addr, 32'h0000_0000);
        check("wr_next_req", {31'd0, imem_req}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
